fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter WIDTH, default 32: instruction and address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, WIDTH: byte address to i_mem rd_addr0, driven directly from the PC register.
REQ-006 SHALL have port imem_data, input, WIDTH: i_mem rd_dout0, valid one cycle after imem_addr is issued.
REQ-007 SHALL have port redirect_valid, input, 1: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, WIDTH: redirect target.
REQ-009 SHALL have port out_valid, output, 1: instruction available to decode.
REQ-010 SHALL have port out_ready, input, 1: decode accepts instruction.
REQ-011 SHALL have port out_pc, output, WIDTH: PC of the presented instruction.
REQ-012 SHALL have port out_instr, output, WIDTH: presented instruction word.

Function
REQ-013 SHALL keep a PC register; a fetch is issued in a cycle when issue_en is high, and the PC advances by 4 in that cycle.
REQ-014 SHALL wrap the PC modulo 2^WIDTH (32'hFFFF_FFFC + 4 = 0).
REQ-015 SHALL track one in-flight flag; the data for a fetch issued in cycle N SHALL be captured into the queue at the end of cycle N+1, tagged with its PC.
REQ-016 SHALL hold fetched instructions in a 2-entry FIFO of {pc, instr}; the FIFO head drives out_pc/out_instr, and out_valid = FIFO not empty.
REQ-017 SHALL compute issue_en = !redirect_valid && (count + inflight - pop) < 2, where pop = out_valid && out_ready; the queue SHALL therefore never overflow.
REQ-018 SHALL complete a transfer when out_valid && out_ready; out_pc/out_instr SHALL stay stable while out_valid && !out_ready.
REQ-019 SHALL sustain 1 instruction/cycle with out_ready held high; the first out_valid SHALL rise 2 cycles after reset deassertion.
REQ-020 On redirect_valid, SHALL load PC <= {redirect_pc[WIDTH-1:2], 2'b00}, flush the FIFO, squash the in-flight fetch (its data is not captured), and issue no fetch that cycle.
REQ-021 SHALL issue the redirect target on the cycle after the redirect; out_valid SHALL be 0 for the 2 cycles after the redirect cycle.
REQ-022 When redirect coincides with a handshake, the transfer SHALL still count as completed for decode, then the flush applies.
REQ-023 When redirect_valid is held for several cycles, SHALL apply the last target and issue nothing until it drops.
REQ-024 SHALL not evaluate instruction contents; illegal encodings pass through unchanged.

Reset
REQ-025 On rst assertion, SHALL immediately set PC = RESET_PC, inflight = 0, FIFO empty, out_valid = 0, and imem_addr = RESET_PC, independent of clk.
REQ-026 out_pc and out_instr SHALL reset to 0.
REQ-027 During and after reset mid-operation, SHALL drop any in-flight data; the first fetch after deassertion is RESET_PC.

Structure
REQ-028 SHALL place RESET_PC default, WIDTH, PC increment (4), and the NOP encoding 32'h0000_0013 in the shared core package.
REQ-029 SHALL implement the queue as sub-module fetch_fifo (2 entries, push/pop/flush, count output), with the PC, in-flight, and redirect logic in fetch_unit.

Verification
REQ-030 Reset release, out_ready=1, i_mem preloaded with word[i]=i: out_pc SHALL sequence 0,4,8,... and out_instr SHALL sequence 0,1,2,... with out_valid first high 2 cycles after reset release.
REQ-031 out_ready=0 for 5 cycles after the first valid: out_pc SHALL hold 0 and imem_addr SHALL stop at 8; on release, out_pc SHALL continue 0,4,8 with no loss or duplicate.
REQ-032 redirect_valid for 1 cycle with redirect_pc=32'h40 while streaming: no instruction from the squashed fetch SHALL appear, and the next out_pc SHALL be 32'h40.
REQ-033 redirect_pc=32'h43: the next imem_addr and out_pc SHALL be 32'h40.
REQ-034 RESET_PC=32'hFFFF_FFF8 with free run: out_pc SHALL sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 rst asserted mid-stream between clock edges: out_valid SHALL drop immediately, and after deassertion out_pc SHALL restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared core constants for the instruction fetch path.
package fetch_unit_pkg;

   localparam int unsigned XLEN             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int unsigned PC_INC           = 4;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   // Fetch queue geometry; the count must be able to represent DEPTH.
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_W      = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch queue of {pc, instr}; entry 0 is always the head.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_flush,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_head,
   output logic              o_valid,
   output logic [CNT_W-1:0]  o_count
);

   logic [DATA_W-1:0] r_e0;
   logic [DATA_W-1:0] r_e1;
   logic [CNT_W-1:0]  r_count;

   logic [DATA_W-1:0] w_e0_n;
   logic [DATA_W-1:0] w_e1_n;
   logic [CNT_W-1:0]  w_count_n;
   logic              w_pop;
   logic              w_push;

   // Next-state of the shift queue; a pop moves entry 1 into the head slot.
   always_comb begin
      w_e0_n    = r_e0;
      w_e1_n    = r_e1;
      w_count_n = r_count;
      w_pop     = i_pop && (r_count != CNT_W'(0));
      w_push    = i_push && ((r_count < CNT_W'(FIFO_DEPTH)) || w_pop);
      if (i_flush) begin
         w_count_n = CNT_W'(0);
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == CNT_W'(0)) w_e0_n = i_data;
               else                      w_e1_n = i_data;
               w_count_n = r_count + CNT_W'(1);
            end
            2'b01: begin
               w_e0_n    = r_e1;
               w_count_n = r_count - CNT_W'(1);
            end
            2'b11: begin
               if (r_count == CNT_W'(1)) begin
                  w_e0_n = i_data;
               end else begin
                  w_e0_n = r_e1;
                  w_e1_n = i_data;
               end
            end
            default: ;
         endcase
      end
   end

   // Queue storage and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_e0    <= '0;
         r_e1    <= '0;
         r_count <= '0;
      end else begin
         r_e0    <= w_e0_n;
         r_e1    <= w_e1_n;
         r_count <= w_count_n;
      end
   end

   assign o_head  = r_e0;
   assign o_valid = (r_count != CNT_W'(0));
   assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, one in-flight i_mem read, redirect and queue.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned      WIDTH    = XLEN,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_data,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_instr
);

   logic [WIDTH-1:0]   r_pc;
   logic               r_inflight;
   logic [WIDTH-1:0]   r_inflight_pc;

   logic               w_pop;
   logic               w_push;
   logic               w_issue;
   logic [2:0]         w_occ;
   logic [CNT_W-1:0]   w_count;
   logic               w_valid;
   logic [2*WIDTH-1:0] w_head;
   logic [WIDTH-1:0]   w_target;

   // Issue only when the queue can absorb everything already owed to it.
   always_comb begin
      w_pop    = w_valid && out_ready;
      w_occ    = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
      w_issue  = !redirect_valid && (w_occ < 3'd2);
      w_push   = r_inflight && !redirect_valid;
      w_target = {redirect_pc[WIDTH-1:2], 2'b00};
   end

   // PC register: redirect wins over sequential advance; wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 r_pc <= RESET_PC;
      else if (redirect_valid) r_pc <= w_target;
      else if (w_issue)        r_pc <= r_pc + WIDTH'(PC_INC);
   end

   // In-flight tracker; a redirect cycle never issues, which squashes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) r_inflight_pc <= r_pc;
      end
   end

   fetch_fifo #(
      .DATA_W (2*WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  ({r_inflight_pc, imem_data}),
      .o_head  (w_head),
      .o_valid (w_valid),
      .o_count (w_count)
   );

   assign imem_addr = r_pc;
   assign out_valid = w_valid;
   assign out_pc    = w_head[2*WIDTH-1:WIDTH];
   assign out_instr = w_head[WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: stream model plus directed scenarios.
module tb_fetch_unit;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] imem_addr, imem_data;
   logic         redirect_valid;
   logic [W-1:0] redirect_pc;
   logic         out_valid, out_ready;
   logic [W-1:0] out_pc, out_instr;

   logic [W-1:0] w_imem_addr, w_imem_data;
   logic         w_valid;
   logic [W-1:0] w_pc, w_instr;
   logic         w_ready    = 1'b1;
   logic         w_redirect = 1'b0;
   logic [W-1:0] w_redir_pc = '0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_unit #(.WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr));

   fetch_unit #(.WIDTH(W), .RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
      .redirect_valid(w_redirect), .redirect_pc(w_redir_pc),
      .out_valid(w_valid), .out_ready(w_ready),
      .out_pc(w_pc), .out_instr(w_instr));

   // i_mem: word i holds value i, one cycle read latency.
   always @(posedge clk) begin
      imem_data   <= imem_addr >> 2;
      w_imem_data <= w_imem_addr >> 2;
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Stream model: accepted PCs run sequentially from the last reset/redirect
   // target, data equals pc/4, valid is low for two cycles after each event.
   int           s = 0;
   logic [W-1:0] exp_pc = '0;
   logic         prev_hold = 1'b0;
   logic [W-1:0] prev_pc, prev_instr;

   always @(negedge clk) begin
      if (rst) begin
         s         = 0;
         exp_pc    = '0;
         prev_hold = 1'b0;
      end else begin
         check("valid_timing", W'(out_valid), W'(s >= 2));
         if (s == 0) check("issue_addr", imem_addr, exp_pc);
         if (prev_hold) begin
            check("hold_pc", out_pc, prev_pc);
            check("hold_instr", out_instr, prev_instr);
         end
         if (out_valid && out_ready) begin
            check("seq_pc", out_pc, exp_pc);
            check("seq_instr", out_instr, exp_pc >> 2);
            exp_pc = exp_pc + W'(4);
         end
         prev_hold  = out_valid && !out_ready && !redirect_valid;
         prev_pc    = out_pc;
         prev_instr = out_instr;
         if (redirect_valid) begin
            exp_pc = {redirect_pc[W-1:2], 2'b00};
            s      = 0;
         end else if (s < 1000) begin
            s++;
         end
      end
   end

   // Wrap-around instance: first three accepted instructions.
   int           w_n = 0;
   logic [W-1:0] w_exp;

   always @(negedge clk) begin
      if (!rst && w_valid && w_n < 3) begin
         case (w_n)
            0:       w_exp = 32'hFFFF_FFF8;
            1:       w_exp = 32'hFFFF_FFFC;
            default: w_exp = 32'h0000_0000;
         endcase
         check("wrap_pc", w_pc, w_exp);
         check("wrap_instr", w_instr, w_exp >> 2);
         w_n++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single-cycle redirect, then pin issue address and first output.
   task automatic redirect_and_check(input logic [W-1:0] tgt, input logic [W-1:0] aligned);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("redir_addr", imem_addr, aligned);
      check("redir_gap1", W'(out_valid), W'(0));
      @(negedge clk);
      check("redir_gap2", W'(out_valid), W'(0));
      @(negedge clk);
      check("redir_valid", W'(out_valid), W'(1));
      check("redir_pc", out_pc, aligned);
   endtask

   logic [19:0] ready_pat = 20'b1011_0010_1110_0110_1001;

   initial begin
      rst            = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", W'(out_valid), W'(0));
      check("rst_addr", imem_addr, 32'h0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_instr", out_instr, 32'h0);
      check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
      rst = 1'b0;

      // Back-pressure from the first valid cycle.
      @(posedge clk);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", W'(out_valid), W'(1));
         check("stall_pc", out_pc, 32'h0);
         check("stall_addr", imem_addr, 32'h8);
      end
      tick();
      out_ready = 1'b1;
      repeat (6) tick();

      redirect_and_check(32'h40, 32'h40);
      repeat (4) tick();
      redirect_and_check(32'h43, 32'h40);
      repeat (3) tick();

      // Held redirect: only the last target takes effect.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_pc    = 32'h200;
      tick();
      redirect_pc    = 32'h304;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("held_addr", imem_addr, 32'h304);
      @(negedge clk);
      @(negedge clk);
      check("held_pc", out_pc, 32'h304);
      tick();

      for (int i = 0; i < 20; i++) begin
         out_ready = ready_pat[i];
         tick();
      end

      // Redirect while decode is stalling.
      out_ready = 1'b0;
      repeat (2) tick();
      redirect_and_check(32'h80, 32'h80);
      tick();
      out_ready = 1'b1;
      repeat (5) tick();

      // Asynchronous reset between clock edges.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", W'(out_valid), W'(0));
      check("mid_rst_addr", imem_addr, 32'h0);
      check("mid_rst_pc", out_pc, 32'h0);
      check("mid_rst_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
      tick();
      rst = 1'b0;
      repeat (8) tick();

      check("wrap_count", W'(w_n), W'(3));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
